// File: rtl/mem_cmd_pkg.sv
// Shared opcodes, status codes and FSM states for the
// UART-to-BRAM command engine.
package mem_cmd_pkg;

   localparam logic [7:0] OP_READ    = 8'h00;
   localparam logic [7:0] OP_WRITE   = 8'h01;
   localparam logic [7:0] OP_FILL    = 8'h02;

   localparam logic [7:0] ST_OK_BASE = 8'hA0;
   localparam logic [7:0] ST_BAD_OP  = 8'hE0;
   localparam logic [7:0] ST_RANGE   = 8'hE1;
   localparam logic [7:0] ST_TIMEOUT = 8'hE2;

   typedef enum logic [3:0] {
      S_IDLE,
      S_HDR,
      S_DISPATCH,
      S_RD_ISSUE,
      S_RD_WAIT,
      S_RD_SEND,
      S_WR_WAIT,
      S_WR_COMMIT,
      S_FILL_WAIT,
      S_FILL,
      S_STATUS,
      S_CKSUM
   } state_t;

   function automatic logic op_known(input logic [7:0] op);
      return (op == OP_READ) || (op == OP_WRITE) || (op == OP_FILL);
   endfunction

endpackage

// File: rtl/mem_cmd_hdr_deser.sv
// Header deserialiser: opcode/START/END assembly (MSB first)
// plus the inter-byte idle timer.
module mem_cmd_hdr_deser #(
   parameter int ADDR_BYTES     = 2,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_hdr,
   input  logic                    timer_en,
   input  logic                    rx_valid,
   input  logic [7:0]              rx_byte,
   output logic [7:0]              opcode,
   output logic [8*ADDR_BYTES-1:0] start_addr,
   output logic [8*ADDR_BYTES-1:0] end_addr,
   output logic                    hdr_done,
   output logic                    timeout
);

   localparam int ADDR_W   = 8 * ADDR_BYTES;
   localparam int HDR_LAST = 2 * ADDR_BYTES;
   localparam int IW       = $clog2(HDR_LAST + 1);
   localparam int CW       = $clog2(TIMEOUT_CYCLES + 1);

   logic [IW-1:0] idx;
   logic [CW-1:0] idle_cnt;

   assign hdr_done = in_hdr && rx_valid && (idx == IW'(HDR_LAST));
   // rx_valid beats an expiring timer in the same cycle
   assign timeout  = timer_en && !rx_valid &&
                     (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         idx        <= '0;
         idle_cnt   <= '0;
         opcode     <= '0;
         start_addr <= '0;
         end_addr   <= '0;
      end else begin
         if (!in_hdr || hdr_done)
            idx <= '0;
         else if (rx_valid)
            idx <= idx + IW'(1);

         if (in_hdr && rx_valid) begin
            if (idx == '0)
               opcode <= rx_byte;
            else if (idx <= IW'(ADDR_BYTES))
               start_addr <= (start_addr << 8) | ADDR_W'(rx_byte);
            else
               end_addr <= (end_addr << 8) | ADDR_W'(rx_byte);
         end

         if (!timer_en || rx_valid)
            idle_cnt <= '0;
         else
            idle_cnt <= idle_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/mem_cmd_engine.sv
// UART-to-BRAM read/write/fill command engine with status reply.
// Define MEM_CMD_CHECKSUM_EN to append a data checksum after success.
module mem_cmd_engine
   import mem_cmd_pkg::*;
#(
   parameter int ADDR_BYTES     = 2,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rx_valid,
   input  logic [7:0]              rx_byte,
   input  logic                    tx_ready,
   output logic                    tx_valid,
   output logic [7:0]              tx_byte,
   output logic                    bram_en,
   output logic                    bram_we,
   output logic [8*ADDR_BYTES-1:0] bram_address,
   output logic [7:0]              bram_byte_write,
   input  logic [7:0]              bram_byte_read,
   output logic                    busy
);

   localparam int ADDR_W = 8 * ADDR_BYTES;

   state_t            state, nstate;
   logic [ADDR_W-1:0] addr, start_addr, end_addr;
   logic [7:0]        opcode, data, rd_data, status;
   logic              holdoff, hdr_done, timeout;
   logic              in_hdr, timer_en, tx_go, at_end;
`ifdef MEM_CMD_CHECKSUM_EN
   logic [7:0]        sum;
`endif

   assign in_hdr   = (state == S_IDLE) || (state == S_HDR);
   assign timer_en = (state == S_HDR) || (state == S_WR_WAIT) ||
                     (state == S_FILL_WAIT);
   // one dead cycle after every strobe while the transmitter drops ready
   assign tx_go    = tx_ready && !holdoff;
   assign at_end   = (addr == end_addr);

   assign busy            = (state != S_IDLE);
   assign bram_address    = addr;
   assign bram_byte_write = data;

   mem_cmd_hdr_deser #(
      .ADDR_BYTES     (ADDR_BYTES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_hdr (
      .clk        (clk),
      .rst        (rst),
      .in_hdr     (in_hdr),
      .timer_en   (timer_en),
      .rx_valid   (rx_valid),
      .rx_byte    (rx_byte),
      .opcode     (opcode),
      .start_addr (start_addr),
      .end_addr   (end_addr),
      .hdr_done   (hdr_done),
      .timeout    (timeout)
   );

   always_comb begin
      nstate   = state;
      tx_valid = 1'b0;
      tx_byte  = 8'h00;
      bram_en  = 1'b0;
      bram_we  = 1'b0;
      unique case (state)
         S_IDLE:
            if (rx_valid) nstate = S_HDR;
         S_HDR:
            if (hdr_done)     nstate = S_DISPATCH;
            else if (timeout) nstate = S_STATUS;
         S_DISPATCH:
            if (!op_known(opcode) || (start_addr > end_addr))
               nstate = S_STATUS;
            else if (opcode == OP_READ)  nstate = S_RD_ISSUE;
            else if (opcode == OP_WRITE) nstate = S_WR_WAIT;
            else                         nstate = S_FILL_WAIT;
         S_RD_ISSUE: begin
            bram_en = 1'b1;
            nstate  = S_RD_WAIT;
         end
         S_RD_WAIT:
            nstate = S_RD_SEND;
         S_RD_SEND: begin
            tx_byte = rd_data;
            if (tx_go) begin
               tx_valid = 1'b1;
               nstate   = at_end ? S_STATUS : S_RD_ISSUE;
            end
         end
         S_WR_WAIT:
            if (rx_valid)     nstate = S_WR_COMMIT;
            else if (timeout) nstate = S_STATUS;
         S_WR_COMMIT: begin
            bram_en = 1'b1;
            bram_we = 1'b1;
            nstate  = at_end ? S_STATUS : S_WR_WAIT;
         end
         S_FILL_WAIT:
            if (rx_valid)     nstate = S_FILL;
            else if (timeout) nstate = S_STATUS;
         S_FILL: begin
            bram_en = 1'b1;
            bram_we = 1'b1;
            nstate  = at_end ? S_STATUS : S_FILL;
         end
         S_STATUS: begin
            tx_byte = status;
            if (tx_go) begin
               tx_valid = 1'b1;
`ifdef MEM_CMD_CHECKSUM_EN
               nstate = (status[7:4] == 4'hA) ? S_CKSUM : S_IDLE;
`else
               nstate = S_IDLE;
`endif
            end
         end
         S_CKSUM: begin
`ifdef MEM_CMD_CHECKSUM_EN
            tx_byte = sum;
            if (tx_go) begin
               tx_valid = 1'b1;
               nstate   = S_IDLE;
            end
`else
            nstate = S_IDLE;
`endif
         end
         default:
            nstate = S_IDLE;
      endcase
      if (rst) begin
         tx_valid = 1'b0;
         bram_en  = 1'b0;
         bram_we  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         addr    <= '0;
         data    <= '0;
         rd_data <= '0;
         status  <= '0;
         holdoff <= 1'b0;
`ifdef MEM_CMD_CHECKSUM_EN
         sum     <= '0;
`endif
      end else begin
         state   <= nstate;
         holdoff <= tx_valid;
         if (timeout)
            status <= ST_TIMEOUT;
         if (state == S_DISPATCH) begin
            addr <= start_addr;
            if (!op_known(opcode))           status <= ST_BAD_OP;
            else if (start_addr > end_addr)  status <= ST_RANGE;
            else                             status <= ST_OK_BASE | opcode;
`ifdef MEM_CMD_CHECKSUM_EN
            sum <= '0;
`endif
         end
         if (state == S_RD_WAIT)
            rd_data <= bram_byte_read;
         if (((state == S_WR_WAIT) || (state == S_FILL_WAIT)) && rx_valid)
            data <= rx_byte;
         // stop on END so the top address never wraps to zero
         if (((state == S_RD_SEND) && tx_valid) || (state == S_WR_COMMIT) ||
             (state == S_FILL))
            if (!at_end) addr <= addr + ADDR_W'(1);
`ifdef MEM_CMD_CHECKSUM_EN
         if ((state == S_RD_SEND) && tx_valid)  sum <= sum + rd_data;
         if ((state == S_WR_WAIT) && rx_valid)  sum <= sum + rx_byte;
         if (state == S_FILL)                   sum <= sum + data;
`endif
      end
   end

endmodule

// File: tb/tb_mem_cmd_engine.sv
// Directed plus randomized command bench for mem_cmd_engine,
// checked against a byte-array memory model and expected replies.
module tb_mem_cmd_engine;

   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_byte = 8'h00;
   logic          tx_ready = 1'b1;
   logic          tx_valid, bram_en, bram_we, busy;
   logic [7:0]    tx_byte, bram_byte_write;
   logic [7:0]    bram_byte_read;
   logic [AW-1:0] bram_address;

   logic ready_fixed = 1'b1;
   logic rand_ready  = 1'b0;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_cmd_engine #(.ADDR_BYTES(2), .TIMEOUT_CYCLES(100)) dut (
      .clk             (clk),
      .rst             (rst),
      .rx_valid        (rx_valid),
      .rx_byte         (rx_byte),
      .tx_ready        (tx_ready),
      .tx_valid        (tx_valid),
      .tx_byte         (tx_byte),
      .bram_en         (bram_en),
      .bram_we         (bram_we),
      .bram_address    (bram_address),
      .bram_byte_write (bram_byte_write),
      .bram_byte_read  (bram_byte_read),
      .busy            (busy)
   );

   logic [7:0] mem     [0:65535];
   logic [7:0] ref_mem [0:65535];

   always @(posedge clk) begin
      if (bram_en && bram_we)  mem[bram_address] <= bram_byte_write;
      if (bram_en && !bram_we) bram_byte_read <= mem[bram_address];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] tx_q[$];
   int tx_cyc[$];
   int wr_cyc[$];
   int en_cnt   = 0;
   int zero_cnt = 0;
   int bad_tx   = 0;
   int last_rx  = 0;

   always @(negedge clk) begin
      if (tx_valid) begin
         tx_q.push_back(tx_byte);
         tx_cyc.push_back(cyc);
         if (!tx_ready) bad_tx <= bad_tx + 1;
      end
      if (bram_en) begin
         en_cnt <= en_cnt + 1;
         if (bram_address == '0) zero_cnt <= zero_cnt + 1;
         if (bram_we) wr_cyc.push_back(cyc);
      end
      if (rx_valid) last_rx <= cyc;
   end

   initial begin
      forever begin
         @(posedge clk);
         #2;
         tx_ready = rand_ready ? ($urandom_range(0, 2) != 0) : ready_fixed;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_byte  = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (busy !== 1'b0 && k < 600) begin
         idle(1);
         k++;
      end
      chk({tag, " done"}, 32'(k < 600), 1);
   endtask

   task automatic do_cmd(input string tag, input logic [7:0] op,
                         input int s, input int e, input logic [7:0] dat[$],
                         output int t0, output int en0, output int w0,
                         output int hcyc, output int dcyc);
      logic [7:0] exp_q[$];
      logic [7:0] sum;
      int n;
      sum = 8'h00;
      t0  = tx_q.size();
      en0 = en_cnt;
      w0  = wr_cyc.size();
      send(op);
      send(s[15:8]);
      send(s[7:0]);
      send(e[15:8]);
      send(e[7:0]);
      hcyc = last_rx;
      dcyc = hcyc;
      if (op > 8'h02) begin
         exp_q.push_back(8'hE0);
      end else if (s > e) begin
         exp_q.push_back(8'hE1);
      end else begin
         n = e - s + 1;
         if (op == 8'h00) begin
            for (int a = s; a <= e; a++) begin
               exp_q.push_back(ref_mem[a]);
               sum = sum + ref_mem[a];
            end
         end else if (op == 8'h01) begin
            for (int i = 0; i < n; i++) begin
               idle($urandom_range(2, 4));
               send(dat[i]);
               ref_mem[s+i] = dat[i];
               sum = sum + dat[i];
            end
            dcyc = last_rx;
         end else begin
            idle($urandom_range(2, 4));
            send(dat[0]);
            for (int a = s; a <= e; a++) begin
               ref_mem[a] = dat[0];
               sum = sum + dat[0];
            end
            dcyc = last_rx;
         end
         exp_q.push_back(8'hA0 | op);
`ifdef MEM_CMD_CHECKSUM_EN
         exp_q.push_back(sum);
`endif
      end
      wait_idle(tag);
      idle(2);
      chk({tag, " len"}, 32'(tx_q.size() - t0), 32'(exp_q.size()));
      foreach (exp_q[i])
         if (t0 + i < tx_q.size())
            chk({tag, " tx"}, 32'(tx_q[t0+i]), 32'(exp_q[i]));
      if (op > 8'h02 || s > e)
         chk({tag, " no_bram"}, 32'(en_cnt - en0), 0);
   endtask

   initial begin
      logic [7:0] dq[$];
      logic [7:0] v;
      int t0, en0, w0, hc, dc, z0, lr, d, mism, r, s, e, op;
      bit ok;

      for (int i = 0; i < 65536; i++) begin
         v = 8'($urandom);
         mem[i] = v;
         ref_mem[i] = v;
      end

      idle(3);
      chk("rst tx_valid", 32'(tx_valid), 0);
      chk("rst bram_en", 32'(bram_en), 0);
      rst = 1'b0;
      idle(1);
      chk("reset tx_valid", 32'(tx_valid), 0);
      chk("reset tx_byte", 32'(tx_byte), 0);
      chk("reset bram_en", 32'(bram_en), 0);
      chk("reset bram_we", 32'(bram_we), 0);
      chk("reset addr", 32'(bram_address), 0);
      chk("reset wdata", 32'(bram_byte_write), 0);
      chk("reset busy", 32'(busy), 0);

      dq = '{8'h11, 8'h22, 8'h33};
      do_cmd("write", 8'h01, 16'h0010, 16'h0012, dq, t0, en0, w0, hc, dc);
      chk("write mem10", 32'(mem[16'h10]), 32'h11);
      chk("write mem11", 32'(mem[16'h11]), 32'h22);
      chk("write mem12", 32'(mem[16'h12]), 32'h33);
      if (wr_cyc.size() > w0)
         chk("write lat", 32'(wr_cyc[wr_cyc.size()-1] - dc), 1);

      dq = {};
      do_cmd("read", 8'h00, 16'h0010, 16'h0012, dq, t0, en0, w0, hc, dc);
      if (tx_cyc.size() > t0)
         chk("read lat", 32'(tx_cyc[t0] - hc), 4);

      dq = '{8'hAA};
      do_cmd("fill", 8'h02, 16'h0020, 16'h002F, dq, t0, en0, w0, hc, dc);
      ok = (wr_cyc.size() - w0 == 16);
      for (int i = 0; i < 16 && ok; i++)
         if (wr_cyc[w0+i] != dc + 1 + i) ok = 1'b0;
      chk("fill consecutive", 32'(ok), 1);
      chk("fill mem2f", 32'(mem[16'h2F]), 32'hAA);

      dq = {};
      do_cmd("range", 8'h00, 16'h0005, 16'h0004, dq, t0, en0, w0, hc, dc);
      do_cmd("badop", 8'h07, 16'h0000, 16'h0000, dq, t0, en0, w0, hc, dc);

      z0 = zero_cnt;
      do_cmd("top", 8'h00, 16'hFFFE, 16'hFFFF, dq, t0, en0, w0, hc, dc);
      chk("top reads", 32'(en_cnt - en0), 2);
      chk("top nowrap", 32'(zero_cnt - z0), 0);

      t0 = tx_q.size();
      send(8'h01);
      send(8'h00);
      send(8'h00);
      lr = last_rx;
      wait_idle("hdr_to");
      idle(2);
      chk("hdr_to len", 32'(tx_q.size() - t0), 1);
      if (tx_q.size() > t0) begin
         chk("hdr_to code", 32'(tx_q[t0]), 32'hE2);
         d = tx_cyc[t0] - lr;
         chk("hdr_to delay", 32'(d >= 100 && d <= 101), 1);
      end
      chk("hdr_to busy", 32'(busy), 0);

      t0 = tx_q.size();
      send(8'h01);
      send(8'h00);
      send(8'h40);
      send(8'h00);
      send(8'h43);
      idle(2);
      send(8'h5A);
      idle(2);
      send(8'h6B);
      ref_mem[16'h40] = 8'h5A;
      ref_mem[16'h41] = 8'h6B;
      wait_idle("wr_to");
      idle(2);
      chk("wr_to len", 32'(tx_q.size() - t0), 1);
      if (tx_q.size() > t0)
         chk("wr_to code", 32'(tx_q[t0]), 32'hE2);
      chk("wr_to kept", 32'(mem[16'h41]), 32'h6B);

      ready_fixed = 1'b0;
      idle(2);
      send(8'h00);
      send(8'h00);
      send(8'h10);
      send(8'h00);
      send(8'h12);
      idle(6);
      t0 = tx_q.size();
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      chk("abort tx_valid", 32'(tx_valid), 0);
      chk("abort tx_byte", 32'(tx_byte), 0);
      chk("abort bram_en", 32'(bram_en), 0);
      chk("abort bram_we", 32'(bram_we), 0);
      chk("abort addr", 32'(bram_address), 0);
      chk("abort busy", 32'(busy), 0);
      ready_fixed = 1'b1;
      idle(10);
      chk("abort no_tx", 32'(tx_q.size() - t0), 0);

      rand_ready = 1'b1;
      for (int k = 0; k < 25; k++) begin
         r = $urandom_range(0, 9);
         op = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3 + r;
         s = $urandom_range(0, 60);
         e = s + $urandom_range(0, 5);
         if ($urandom_range(0, 9) == 0) begin
            d = s;
            s = e + 1;
            e = d;
         end
         dq = {};
         for (int i = 0; i <= e - s; i++) dq.push_back(8'($urandom));
         if (dq.size() == 0) dq.push_back(8'($urandom));
         do_cmd("rand", 8'(op), s, e, dq, t0, en0, w0, hc, dc);
      end
      rand_ready = 1'b0;

      mism = 0;
      for (int a = 0; a < 65536; a++)
         if (mem[a] !== ref_mem[a]) mism++;
      chk("mem model", 32'(mism), 0);
      chk("tx_ready obeyed", 32'(bad_tx), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
